// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running minimum SAD / index tracker over a fixed number of beats
//
// Purpose: accepts BEATS beats of three (sad, index) candidate pairs per search,
// reduces each beat to its lane minimum and keeps the overall minimum with its index.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin (or restart) a search
//   in_valid / in_ready        beat handshake; accepted when both high
//   sad_in1..3, index_in1..3   candidate SADs and their indices
//   best_sad, best_index       current/final minimum and its index
//   busy                       search in progress
//   out_valid                  result final, held until next start
//   done                       one-cycle pulse when the result becomes final

module sad_min_tracker #(
    parameter int SAD_W = 32,
    parameter int IDX_W = 32,
    parameter int BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SAD_W-1:0] sad_in1,
    input  logic [SAD_W-1:0] sad_in2,
    input  logic [SAD_W-1:0] sad_in3,
    input  logic [IDX_W-1:0] index_in1,
    input  logic [IDX_W-1:0] index_in2,
    input  logic [IDX_W-1:0] index_in3,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_index,
    output logic             busy,
    output logic             out_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;

    logic [SAD_W-1:0] min12_sad;
    logic [IDX_W-1:0] min12_idx;
    logic [SAD_W-1:0] lane_sad;
    logic [IDX_W-1:0] lane_idx;
    logic             beat_accept;

    assign busy        = (state == ACCUM);
    assign in_ready    = (state == ACCUM) && !start;
    assign beat_accept = in_valid && in_ready;

    // Strict < at each stage so an equal SAD never displaces a lower-numbered lane.
    always_comb begin
        min12_sad = sad_in1;
        min12_idx = index_in1;
        if (sad_in2 < sad_in1) begin
            min12_sad = sad_in2;
            min12_idx = index_in2;
        end
        lane_sad = min12_sad;
        lane_idx = min12_idx;
        if (sad_in3 < min12_sad) begin
            lane_sad = sad_in3;
            lane_idx = index_in3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            best_sad   <= '0;
            best_index <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ACCUM;
                        beat_cnt  <= '0;
                        out_valid <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        // Restart: a zero count makes the next beat reload best unconditionally.
                        beat_cnt <= '0;
                    end else if (beat_accept) begin
                        if ((beat_cnt == '0) || (lane_sad < best_sad)) begin
                            best_sad   <= lane_sad;
                            best_index <= lane_idx;
                        end
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_CNT) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
